cam_match_reader: RTL and testbench

CAM_MATCH_READER -- requirements
Module: cam_match_reader

---
 rtl/cam_match_reader.sv | 182 ++++++++++++++++++
 tb/tb_cam_match_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_match_reader.sv
// cam_match_reader: walks the matched rows of a CAM search result in
// ascending row order. For each row it issues a read and presents the row
// data on a valid/ready output port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// CAPTURE  | latch tag_row into the pending mask and its popcount
// SCAN     | pick the lowest pending row, or finish if none is left
// ISSUE    | row address driven; wait READ_LAT cycles for array data
// OUT      | first cycle captures Q_out_row, then hold the beat until ready
// DONE     | one-cycle completion pulse
module cam_match_reader #(
    parameter int         DATA_WIDTH     = 8,
    parameter int         DATA_DEPTH     = 16,
    parameter int         ADDR_WIDTH_CAM = 8,
    parameter int         READ_LAT       = 2,
    parameter logic [2:0] RowxRow        = 3'd1
) (
    input  logic                               clk,
    input  logic                               rstIn,
    input  logic                               start,
    input  logic                               abort,
    input  logic [DATA_DEPTH-1:0]              tag_row,
    input  logic [DATA_WIDTH-1:0]              Q_out_row,
    output logic [ADDR_WIDTH_CAM-1:0]          addr_output_Row,
    output logic [2:0]                         rd_mode,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [ADDR_WIDTH_CAM-1:0]          out_addr,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(DATA_DEPTH+1)-1:0]    match_count
);

    localparam int CNT_W = $clog2(DATA_DEPTH + 1);
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_WIDTH_CAM-1:0] ADDR_OFF = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
    localparam logic [LAT_W-1:0]          LAT_LOAD = LAT_W'(READ_LAT - 1);
    localparam logic [DATA_DEPTH-1:0]     ONE_HOT0 = DATA_DEPTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_SCAN, S_ISSUE, S_OUT, S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [DATA_DEPTH-1:0]       pend_q, pend_d;
    logic [ADDR_WIDTH_CAM-1:0]   sel_q, sel_d;
    logic [LAT_W-1:0]            lat_q, lat_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [ADDR_WIDTH_CAM-1:0]   out_addr_q, out_addr_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;
    logic [CNT_W-1:0]            match_count_q, match_count_d;

    logic [ADDR_WIDTH_CAM-1:0]   low_idx;
    logic [CNT_W-1:0]            pop;
    logic [DATA_DEPTH-1:0]       sel_mask;
    logic                        hs;
    logic                        kill;

    // Lowest set bit of the pending mask and popcount of the live tag vector
    always_comb begin
        low_idx = '0;
        for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = ADDR_WIDTH_CAM'(i);
        end
        pop = '0;
        for (int i = 0; i < DATA_DEPTH; i++) begin
            pop = pop + CNT_W'(tag_row[i]);
        end
    end

    assign sel_mask = ONE_HOT0 << sel_q;
    assign hs       = (state_q == S_OUT) && out_valid_q && out_ready;
    assign kill     = abort && (state_q != S_IDLE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            sel_q         <= '0;
            lat_q         <= '0;
            out_data_q    <= '0;
            out_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            sel_q         <= sel_d;
            lat_q         <= lat_d;
            out_data_q    <= out_data_d;
            out_addr_q    <= out_addr_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            match_count_q <= match_count_d;
        end
    end

    // Next-state logic; abort overrides everything once a read-out is running
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SCAN;
            S_SCAN:    state_d = (|pend_q) ? S_ISSUE : S_DONE;
            S_ISSUE:   if (lat_q == '0) state_d = S_OUT;
            S_OUT:     if (hs) state_d = S_SCAN;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    // Datapath updates: mask capture, row select, latency timer, beat register
    always_comb begin
        pend_d        = pend_q;
        sel_d         = sel_q;
        lat_d         = lat_q;
        out_data_d    = out_data_q;
        out_addr_d    = out_addr_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        match_count_d = match_count_q;
        case (state_q)
            S_CAPTURE: begin
                pend_d        = tag_row;
                match_count_d = pop;
            end
            S_SCAN: begin
                sel_d = low_idx;
                lat_d = LAT_LOAD;
            end
            S_ISSUE: begin
                if (lat_q != '0) lat_d = lat_q - 1'b1;
            end
            S_OUT: begin
                if (!out_valid_q) begin
                    // Array data is valid now that the address has been stable READ_LAT cycles
                    out_data_d  = Q_out_row;
                    out_addr_d  = sel_q;
                    out_last_d  = ((pend_q & ~sel_mask) == '0);
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    pend_d      = pend_q & ~sel_mask;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            default: ;
        endcase
        // An accepted beat still retires its row even when abort lands on the same edge
        if (kill) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Outputs decoded from state; the array sees the disable code outside reads
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        rd_mode         = 3'd0;
        addr_output_Row = ADDR_OFF;
        if (state_q == S_ISSUE || state_q == S_OUT) begin
            rd_mode         = RowxRow;
            addr_output_Row = sel_q;
        end
    end

    assign out_data    = out_data_q;
    assign out_addr    = out_addr_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_cam_match_reader.sv
// Directed bench for cam_match_reader with a READ_LAT=2 array model.
module tb_cam_match_reader;

    logic        clk;
    logic        rstIn;
    logic        start;
    logic        abort;
    logic [15:0] tag_row;
    logic [7:0]  Q_out_row;
    logic [7:0]  addr_output_Row;
    logic [2:0]  rd_mode;
    logic [7:0]  out_data;
    logic [7:0]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [4:0]  match_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] addr_p1 = 8'd19;
    logic [7:0] addr_p2 = 8'd19;

    cam_match_reader dut (
        .clk             (clk),
        .rstIn           (rstIn),
        .start           (start),
        .abort           (abort),
        .tag_row         (tag_row),
        .Q_out_row       (Q_out_row),
        .addr_output_Row (addr_output_Row),
        .rd_mode         (rd_mode),
        .out_data        (out_data),
        .out_addr        (out_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done),
        .match_count     (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array contents: rows 2, 5, 15 fixed; other rows {i, ~i}
    function automatic logic [7:0] mem_val(input logic [7:0] a);
        case (a)
            8'd2:    return 8'hA2;
            8'd5:    return 8'h55;
            8'd15:   return 8'hFF;
            default: return (a < 8'd16) ? {a[3:0], ~a[3:0]} : 8'h00;
        endcase
    endfunction

    // Two-cycle read pipeline of the array
    always @(posedge clk) begin
        addr_p1 <= addr_output_Row;
        addr_p2 <= addr_p1;
    end
    assign Q_out_row = mem_val(addr_p2);

    task automatic test_reset();
        rstIn = 1'b0; start = 1'b0; abort = 1'b0; tag_row = 16'h0; out_ready = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (addr_output_Row !== 8'd19) begin errors++; $display("FAIL reset_addr got=%0d exp=19", addr_output_Row); end
        checks++; if (rd_mode !== 3'd0) begin errors++; $display("FAIL reset_rd_mode got=%0d exp=0", rd_mode); end
        checks++; if (match_count !== 5'd0) begin errors++; $display("FAIL reset_match_count got=%0d exp=0", match_count); end
        @(posedge clk); #1 rstIn = 1'b1;
    endtask

    // One read-out: start with tag, optional ready toggling, abort after first beat,
    // or disturbance (tag change + start re-pulse) after CAPTURE.
    task automatic run_seq(input string name, input logic [15:0] tag, input bit toggle_ready,
                           input bit do_abort, input bit disturb);
        int exp_addr[16];
        int n_exp = 0;
        int beats = 0;
        int done_cnt = 0;
        int first_done = -1;
        int exp_valid_iter = 5;
        bit new_beat = 1'b1;
        bit stall = 1'b0;
        bit pend_abort = 1'b0;
        bit chk_idle = 1'b0;
        bit finished = 1'b0;
        logic [7:0] s_data, s_addr;
        logic s_last;
        int exp_beats;
        for (int i = 0; i < 16; i++) if (tag[i]) begin exp_addr[n_exp] = i; n_exp++; end
        exp_beats = do_abort ? 1 : n_exp;

        @(posedge clk); #1 tag_row = tag; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== s_data || out_addr !== s_addr || out_last !== s_last) begin
                    errors++;
                    $display("FAIL %s stall_hold got v=%0b d=%h a=%0d l=%0b exp v=1 d=%h a=%0d l=%0b",
                             name, out_valid, out_data, out_addr, out_last, s_data, s_addr, s_last);
                end
                stall = 1'b0;
            end
            if (chk_idle) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s abort_busy got=%0b exp=0", name, busy); end
                chk_idle = 1'b0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
            end
            if (out_valid === 1'b1) begin
                if (new_beat) begin
                    checks++;
                    if (cyc != exp_valid_iter) begin
                        errors++; $display("FAIL %s valid_timing got=%0d exp=%0d", name, cyc, exp_valid_iter);
                    end
                    new_beat = 1'b0;
                end
                checks++;
                if (rd_mode !== 3'd1 || addr_output_Row !== out_addr) begin
                    errors++; $display("FAIL %s read_port got mode=%0d addr=%0d exp mode=1 addr=%0d",
                                       name, rd_mode, addr_output_Row, out_addr);
                end
                if (out_ready === 1'b1) begin
                    checks++;
                    if (beats >= exp_beats) begin
                        errors++; $display("FAIL %s extra_beat got=%0d exp=%0d beats", name, beats + 1, exp_beats);
                    end else if (out_addr !== 8'(exp_addr[beats]) || out_data !== mem_val(8'(exp_addr[beats]))
                                 || out_last !== (beats == n_exp - 1)) begin
                        errors++;
                        $display("FAIL %s beat%0d got a=%0d d=%h l=%0b exp a=%0d d=%h l=%0b", name, beats,
                                 out_addr, out_data, out_last, exp_addr[beats],
                                 mem_val(8'(exp_addr[beats])), (beats == n_exp - 1));
                    end
                    beats++;
                    new_beat = 1'b1;
                    exp_valid_iter = cyc + 5;
                    if (do_abort && beats == 1) pend_abort = 1'b1;
                end else begin
                    stall = 1'b1; s_data = out_data; s_addr = out_addr; s_last = out_last;
                end
            end
            if (busy === 1'b0 && cyc > 0) begin finished = 1'b1; break; end
            @(posedge clk); #1;
            if (toggle_ready) out_ready = ~out_ready;
            if (abort) begin abort = 1'b0; chk_idle = 1'b1; end
            else if (pend_abort) begin abort = 1'b1; pend_abort = 1'b0; end
            if (disturb && cyc == 3) begin tag_row = 16'h00FF; start = 1'b1; end
            else start = 1'b0;
        end
        abort = 1'b0; start = 1'b0;
        checks++; if (!finished) begin errors++; $display("FAIL %s timeout got=busy exp=idle", name); end
        checks++; if (beats != exp_beats) begin errors++; $display("FAIL %s beat_count got=%0d exp=%0d", name, beats, exp_beats); end
        checks++;
        if (done_cnt != (do_abort ? 0 : 1)) begin
            errors++; $display("FAIL %s done_count got=%0d exp=%0d", name, done_cnt, do_abort ? 0 : 1);
        end
        checks++;
        if (match_count !== 5'($countones(tag))) begin
            errors++; $display("FAIL %s match_count got=%0d exp=%0d", name, match_count, $countones(tag));
        end
        checks++;
        if (addr_output_Row !== 8'd19 || rd_mode !== 3'd0) begin
            errors++; $display("FAIL %s idle_port got addr=%0d mode=%0d exp addr=19 mode=0", name, addr_output_Row, rd_mode);
        end
        if (tag == 16'h0) begin
            checks++; if (first_done != 2) begin errors++; $display("FAIL %s done_latency got=%0d exp=2", name, first_done); end
        end
    endtask

    task automatic test_basic();        run_seq("basic", 16'h8024, 1'b0, 1'b0, 1'b0); endtask
    task automatic test_empty();        run_seq("empty", 16'h0000, 1'b0, 1'b0, 1'b0); endtask
    task automatic test_back_to_back(); run_seq("all_stall", 16'hFFFF, 1'b1, 1'b0, 1'b0); endtask
    task automatic test_abort();        run_seq("abort", 16'h0011, 1'b0, 1'b1, 1'b0); endtask
    task automatic test_disturb();      run_seq("disturb", 16'h8024, 1'b0, 1'b0, 1'b1); endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 tag_row = 16'h8024; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rd_mode !== 3'd1) begin errors++; $display("FAIL rmid_in_issue got mode=%0d exp=1", rd_mode); end
        rstIn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || rd_mode !== 3'd0
            || addr_output_Row !== 8'd19 || match_count !== 5'd0 || out_data !== 8'h00 || out_addr !== 8'h00) begin
            errors++;
            $display("FAIL rmid_outputs got b=%0b dn=%0b v=%0b l=%0b m=%0d a=%0d mc=%0d d=%h oa=%0d exp 0 0 0 0 0 19 0 00 0",
                     busy, done, out_valid, out_last, rd_mode, addr_output_Row, match_count, out_data, out_addr);
        end
        @(posedge clk); #1 rstIn = 1'b1;
        run_seq("after_reset", 16'h8024, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_back_to_back();
        test_abort();
        test_disturb();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
